busy_table_ckpt: RTL and testbench

BUSY_TABLE_CKPT -- requirements
Module: busy_table_ckpt

---
 rtl/busy_pkg.sv | 19 +
 rtl/busy_snapshot.sv | 29 ++
 rtl/busy_table_ckpt.sv | 140 ++++++++++++++
 tb/tb_busy_table_ckpt.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/busy_pkg.sv
// Shared defaults for the busy table with checkpoints, plus a constant-safe clog2.
package busy_pkg;

    localparam int unsigned BUSY_WIDTH = 6;
    localparam int unsigned BUSY_NREAD = 8;
    localparam int unsigned BUSY_NSET  = 4;
    localparam int unsigned BUSY_NCLR  = 4;
    localparam int unsigned BUSY_NCKPT = 4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/busy_snapshot.sv
// One checkpoint slot: loads a busy image, and keeps absorbing writeback clears
// so that a later restore does not resurrect registers already produced.
module busy_snapshot
    import busy_pkg::*;
#(
    parameter int unsigned SIZE = 2 ** BUSY_WIDTH
) (
    input  logic            clk_i,
    input  logic            load_i,
    input  logic [SIZE-1:0] data_i,
    input  logic [SIZE-1:0] clr_vec_i,
    output logic [SIZE-1:0] snap_o
);

    logic [SIZE-1:0] snap_q;
    logic [SIZE-1:0] snap_d;

    // Load data arrives already masked by this cycle's clears.
    always_comb begin
        snap_d = load_i ? data_i : (snap_q & ~clr_vec_i);
    end

    always_ff @(posedge clk_i) begin
        snap_q <= snap_d;
    end

    assign snap_o = snap_q;

endmodule

// File: rtl/busy_table_ckpt.sv
// Physical-register busy table with a circular FIFO of checkpoints used for
// branch-mispredict recovery.
module busy_table_ckpt
    import busy_pkg::*;
#(
    parameter  int unsigned WIDTH = BUSY_WIDTH,
    parameter  int unsigned NREAD = BUSY_NREAD,
    parameter  int unsigned NSET  = BUSY_NSET,
    parameter  int unsigned NCLR  = BUSY_NCLR,
    parameter  int unsigned NCKPT = BUSY_NCKPT,
    localparam int unsigned CW    = clog2(NCKPT)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NREAD*WIDTH-1:0] i_raddr,
    output logic [NREAD-1:0]       o_busy,
    input  logic [NSET-1:0]        i_set_vld,
    input  logic [NSET*WIDTH-1:0]  i_set_addr,
    input  logic [NCLR-1:0]        i_clr_vld,
    input  logic [NCLR*WIDTH-1:0]  i_clr_addr,
    input  logic                   i_save,
    output logic [CW-1:0]          o_save_id,
    output logic                   o_full,
    input  logic                   i_free,
    input  logic                   i_restore,
    input  logic [CW-1:0]          i_restore_id,
    output logic                   o_restore_err
);

    localparam int unsigned SIZE = 2 ** WIDTH;
    localparam int unsigned NW   = CW + 1;

    logic [SIZE-1:0] busy_q, busy_d;
    logic [SIZE-1:0] set_vec, clr_vec, snap_src;
    logic [CW-1:0]   head_q, head_d;
    logic [CW-1:0]   tail_q, tail_d;
    logic [NW-1:0]   count_q, count_d;
    logic            err_q, err_d;

    logic [SIZE-1:0] snap [NCKPT];
    logic [NCKPT-1:0] load;

    logic          full;
    logic [CW-1:0] rst_off;
    logic          restore_ok;
    logic          save_ok;
    logic          free_ok;

    // Register 0 is hard-wired idle, so it is dropped from both decode vectors.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int unsigned k = 0; k < NSET; k++) begin
            if (i_set_vld[k]) set_vec[i_set_addr[k*WIDTH +: WIDTH]] = 1'b1;
        end
        for (int unsigned k = 0; k < NCLR; k++) begin
            if (i_clr_vld[k]) clr_vec[i_clr_addr[k*WIDTH +: WIDTH]] = 1'b1;
        end
        set_vec[0] = 1'b0;
        clr_vec[0] = 1'b0;
    end

    always_comb begin
        o_busy = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            o_busy[k] = busy_q[i_raddr[k*WIDTH +: WIDTH]] & ~clr_vec[i_raddr[k*WIDTH +: WIDTH]];
        end
    end

    // A slot is live when its distance from head is below the live count.
    always_comb begin
        full       = (count_q == NW'(NCKPT));
        rst_off    = i_restore_id - head_q;
        restore_ok = i_restore & ({1'b0, rst_off} < count_q);
        free_ok    = i_free & (count_q != '0) & ~restore_ok;
        save_ok    = i_save & ~restore_ok & (~full | free_ok);
        snap_src   = busy_q & ~clr_vec;
        err_d      = i_restore & ~restore_ok;
    end

    always_comb begin
        busy_d  = (busy_q | set_vec) & ~clr_vec;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (restore_ok) begin
            busy_d  = snap[i_restore_id] & ~clr_vec;
            tail_d  = i_restore_id;
            count_d = {1'b0, rst_off};
        end else begin
            if (free_ok) head_d = head_q + CW'(1);
            if (save_ok) tail_d = tail_q + CW'(1);
            case ({save_ok, free_ok})
                2'b10:   count_d = count_q + NW'(1);
                2'b01:   count_d = count_q - NW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < NCKPT; i++) begin
            load[i] = save_ok & (tail_q == CW'(i));
        end
    end

    for (genvar g = 0; g < NCKPT; g++) begin : g_slot
        busy_snapshot #(
            .SIZE(SIZE)
        ) u_snap (
            .clk_i    (i_clk),
            .load_i   (load[g]),
            .data_i   (snap_src),
            .clr_vec_i(clr_vec),
            .snap_o   (snap[g])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign o_full        = full;
    assign o_save_id     = tail_q;
    assign o_restore_err = err_q;

endmodule

// File: tb/tb_busy_table_ckpt.sv
// Directed scoreboard bench for busy_table_ckpt: stimulus pushes expectations,
// a negedge monitor pops and compares them in the cycle they were issued.
module tb_busy_table_ckpt;

    localparam int unsigned W  = 6;
    localparam int unsigned NR = 8;
    localparam int unsigned NS = 4;
    localparam int unsigned NC = 4;
    localparam int unsigned NK = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*W-1:0] raddr;
    logic [NR-1:0]   busy;
    logic [NS-1:0]   set_vld;
    logic [NS*W-1:0] set_addr;
    logic [NC-1:0]   clr_vld;
    logic [NC*W-1:0] clr_addr;
    logic            save;
    logic [1:0]      save_id;
    logic            full;
    logic            free;
    logic            restore;
    logic [1:0]      restore_id;
    logic            restore_err;

    always #5 clk = ~clk;

    busy_table_ckpt #(
        .WIDTH(W),
        .NREAD(NR),
        .NSET (NS),
        .NCLR (NC),
        .NCKPT(NK)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_raddr      (raddr),
        .o_busy       (busy),
        .i_set_vld    (set_vld),
        .i_set_addr   (set_addr),
        .i_clr_vld    (clr_vld),
        .i_clr_addr   (clr_addr),
        .i_save       (save),
        .o_save_id    (save_id),
        .o_full       (full),
        .i_free       (free),
        .i_restore    (restore),
        .i_restore_id (restore_id),
        .o_restore_err(restore_err)
    );

    typedef enum int {K_BUSY, K_FULL, K_SID, K_ERR} kind_t;
    typedef struct {
        int unsigned when;
        kind_t       kind;
        int unsigned idx;
        int unsigned val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc    = 0;
    int          n_vec  = 0;
    int          n_bad  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t        e;
        int unsigned act;
        while (sb.size() > 0 && sb[0].when <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_BUSY:  act = {31'd0, busy[e.idx]};
                K_FULL:  act = {31'd0, full};
                K_SID:   act = {30'd0, save_id};
                default: act = {31'd0, restore_err};
            endcase
            n_vec++;
            if (e.when != cyc || act != e.val) begin
                n_bad++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
    end

    task automatic expect_v(input string name, input kind_t k, input int unsigned idx,
                            input int unsigned v);
        exp_t e;
        e.when = cyc;
        e.kind = k;
        e.idx  = idx;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        set_vld    = '0;
        clr_vld    = '0;
        save       = 1'b0;
        free       = 1'b0;
        restore    = 1'b0;
        restore_id = '0;
    endtask

    task automatic st(input int unsigned p, input int unsigned a);
        set_vld[p]          = 1'b1;
        set_addr[p*W +: W]  = W'(a);
    endtask

    task automatic cl(input int unsigned p, input int unsigned a);
        clr_vld[p]          = 1'b1;
        clr_addr[p*W +: W]  = W'(a);
    endtask

    task automatic chk_busy(input string name, input int unsigned p, input int unsigned a,
                            input int unsigned v);
        raddr[p*W +: W] = W'(a);
        expect_v(name, K_BUSY, p, v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        raddr      = '0;
        set_vld    = '0;
        set_addr   = '0;
        clr_vld    = '0;
        clr_addr   = '0;
        save       = 1'b0;
        free       = 1'b0;
        restore    = 1'b0;
        restore_id = '0;

        nxt();
        chk_busy("rst_busy", 0, 5, 0);
        expect_v("rst_full", K_FULL, 0, 0);
        expect_v("rst_sid", K_SID, 0, 0);
        expect_v("rst_err", K_ERR, 0, 0);

        // basic set / read, including register 0
        nxt(); rst = 1'b0;
        st(0, 5); st(1, 9); st(2, 0);
        chk_busy("set_not_fwd", 0, 5, 0);
        nxt();
        chk_busy("rd5", 0, 5, 1);
        chk_busy("rd9", 1, 9, 1);
        chk_busy("rd0", 2, 0, 0);

        // clear bypass and clear-over-set
        st(0, 7);
        nxt();
        cl(0, 7);
        chk_busy("clr_fwd7", 0, 7, 0);
        chk_busy("other5", 1, 5, 1);
        nxt();
        st(0, 7); cl(1, 7);
        chk_busy("setclr_rd7", 0, 7, 0);
        nxt();
        chk_busy("clr_wins7", 0, 7, 0);

        // restore discards same-cycle-and-later sets
        st(0, 3);
        nxt();
        save = 1'b1; st(0, 4);
        expect_v("save0_sid", K_SID, 0, 0);
        nxt();
        st(0, 6);
        expect_v("after_save_sid", K_SID, 0, 1);
        chk_busy("rd4_pre", 1, 4, 1);
        nxt();
        restore = 1'b1; restore_id = 2'd0; st(1, 8);
        chk_busy("rd6_pre", 0, 6, 1);
        nxt();
        chk_busy("rst0_3", 0, 3, 1);
        chk_busy("rst0_4", 1, 4, 0);
        chk_busy("rst0_6", 2, 6, 0);
        chk_busy("rst0_5", 3, 5, 1);
        chk_busy("rst0_set_ign", 4, 8, 0);
        expect_v("rst0_sid", K_SID, 0, 0);
        expect_v("rst0_full", K_FULL, 0, 0);
        // restore with nothing live: error, normal set proceeds
        restore = 1'b1; restore_id = 2'd0; st(0, 11);
        nxt();
        expect_v("err_pulse", K_ERR, 0, 1);
        chk_busy("err_set11", 0, 11, 1);
        chk_busy("err_keep3", 1, 3, 1);
        nxt();
        expect_v("err_clear", K_ERR, 0, 0);

        // clear propagates into live snapshot
        nxt();
        save = 1'b1;
        expect_v("save_b_sid", K_SID, 0, 0);
        nxt();
        cl(0, 3);
        chk_busy("clr3_fwd", 0, 3, 0);
        nxt();
        restore = 1'b1; restore_id = 2'd0;
        nxt();
        chk_busy("snap_clr3", 0, 3, 0);
        chk_busy("snap_5", 1, 5, 1);
        chk_busy("snap_11", 2, 11, 1);
        expect_v("snap_err", K_ERR, 0, 0);

        // fill, overflow, save+free while full, drain
        for (int i = 0; i < 4; i++) begin
            nxt();
            save = 1'b1;
            expect_v("fill_sid", K_SID, 0, i);
            expect_v("fill_full", K_FULL, 0, 0);
        end
        nxt();
        save = 1'b1;
        expect_v("full_set", K_FULL, 0, 1);
        expect_v("full_sid", K_SID, 0, 0);
        nxt();
        save = 1'b1; free = 1'b1;
        expect_v("ovf_ign_sid", K_SID, 0, 0);
        expect_v("ovf_ign_full", K_FULL, 0, 1);
        nxt();
        save = 1'b1; free = 1'b1;
        expect_v("sf1_sid", K_SID, 0, 1);
        expect_v("sf1_full", K_FULL, 0, 1);
        nxt();
        free = 1'b1;
        expect_v("sf2_sid", K_SID, 0, 2);
        expect_v("sf2_full", K_FULL, 0, 1);
        nxt();
        free = 1'b1;
        expect_v("drain_full", K_FULL, 0, 0);
        nxt(); free = 1'b1;
        nxt(); free = 1'b1;
        nxt(); free = 1'b1;
        nxt();
        expect_v("drain_full2", K_FULL, 0, 0);
        expect_v("drain_sid", K_SID, 0, 2);
        save = 1'b1;
        nxt();
        expect_v("post_drain_sid", K_SID, 0, 3);
        restore = 1'b1; restore_id = 2'd2;
        nxt();
        expect_v("head_rst_err", K_ERR, 0, 0);
        expect_v("head_rst_sid", K_SID, 0, 2);

        // reset mid-operation discards checkpoints
        save = 1'b1;
        nxt();
        rst = 1'b1;
        expect_v("mid_rst_sid", K_SID, 0, 0);
        expect_v("mid_rst_full", K_FULL, 0, 0);
        chk_busy("mid_rst_busy5", 0, 5, 0);
        nxt();
        rst = 1'b0;
        st(0, 10);

        // partial restore and restore to a released slot
        nxt();
        save = 1'b1;
        expect_v("r41_sid0", K_SID, 0, 0);
        nxt();
        save = 1'b1; st(0, 11);
        expect_v("r41_sid1", K_SID, 0, 1);
        nxt();
        save = 1'b1; st(0, 12);
        expect_v("r41_sid2", K_SID, 0, 2);
        nxt();
        restore = 1'b1; restore_id = 2'd1;
        expect_v("r41_sid3", K_SID, 0, 3);
        nxt();
        expect_v("r41_rst_sid", K_SID, 0, 1);
        chk_busy("r41_10", 0, 10, 1);
        chk_busy("r41_11", 1, 11, 0);
        chk_busy("r41_12", 2, 12, 0);
        restore = 1'b1; restore_id = 2'd2; st(0, 20);
        nxt();
        expect_v("r41_err", K_ERR, 0, 1);
        expect_v("r41_err_sid", K_SID, 0, 1);
        chk_busy("r41_err20", 3, 20, 1);
        chk_busy("r41_err10", 0, 10, 1);
        nxt();
        expect_v("r41_err_off", K_ERR, 0, 0);
        restore = 1'b1; restore_id = 2'd0;
        nxt();
        expect_v("r41_fin_sid", K_SID, 0, 0);
        chk_busy("r41_fin10", 0, 10, 1);
        chk_busy("r41_fin20", 3, 20, 0);

        nxt();
        nxt();
        if (sb.size() != 0) begin
            $display("FAIL leftover: got %0d unchecked expected 0", sb.size());
            n_bad += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
